ulpi_reg_ctrl: RTL
==================

Name: ulpi_reg_ctrl

Overview:
- Link-side ULPI register-access controller in the 60 MHz ULPI clock domain, between the ULPI IO buffers and top_core's register clients.
- After reset it sequences PHY configuration writes that put the PHY in non-driving sniff mode.
- It then arbitrates a single external register read/write port against PHY-owned bus time (dir).
- It also extracts RX CMD bytes (linestate/event) for the capture logic.

Parameters:
- INIT_DELAY, 16'd6000: cycles after reset release before the first PHY access (100 us at 60 MHz).
- OTG_CTRL_INIT, 8'h00: value written to OTG Control (addr 6'h0A).
- FUNC_CTRL_INIT, 8'h48: value written to Function Control (addr 6'h04). SuspendM=1, OpMode=01 non-driving, XcvrSel=00 HS.
- TIMEOUT, 8'd255: max cycles waiting for nxt in any bus-driving state.
- MAX_RETRY, 4'd8: aborts tolerated per access before it is failed.

Ports:
- clk_i  in  1  ULPI 60 MHz clock.
- rst_i  in  1  asynchronous reset, active-low.
- ulpi_data_i  in  8  ULPI data from PHY.
- ulpi_data_o  out  8  ULPI data to PHY; buffer output-enabled when dir low.
- ulpi_dir_i  in  1  PHY bus ownership.
- ulpi_nxt_i  in  1  PHY throttle.
- ulpi_stp_o  out  1  ULPI stop.
- reg_req_i  in  1  external access request; held until ack.
- reg_we_i  in  1  1=write, 0=read.
- reg_addr_i  in  6  PHY register address.
- reg_wdata_i  in  8  write data.
- reg_ack_o  out  1  one-cycle completion pulse.
- reg_err_o  out  1  valid with ack; timeout or retry exhaustion.
- reg_rdata_o  out  8  read data; valid with ack, held until next ack.
- init_done_o  out  1  configuration sequence complete (sticky).
- rxcmd_o  out  8  last RX CMD byte.
- rxcmd_valid_o  out  1  one-cycle pulse per new RX CMD.

Behaviour:
- Reset values: all outputs 0. FSM in WAIT_INIT; delay, timeout and retry counters 0.
- Reset asserted mid-access: all outputs drop to 0 immediately and the transaction is lost. The PHY recovers via its own stp/dir handling.
- States:
  - WAIT_INIT: count INIT_DELAY, then go to IDLE with the internal requester holding write OTG_CTRL_INIT@0A, then write FUNC_CTRL_INIT@04.
  - IDLE: accept a request only when dir=0 and dir was 0 the previous cycle (no turnaround). Internal requests have priority; external requests are accepted only when init_done_o=1. On accept, latch we/addr/wdata, clear the timeout counter, go to CMD.
  - CMD: drive TXCMD {we?2'b10:2'b11, addr}. If nxt=1 and dir=0: write goes to WDATA, read goes to RTURN; data_o goes to 0.
  - WDATA: drive wdata. On nxt=1 go to STP.
  - STP: stp_o=1 and data_o=0 for exactly one cycle. Then ack, err=0, return to IDLE.
  - RTURN: requires dir=1 and nxt=0 on the cycle after CMD completion (turnaround; data ignored). Next cycle go to RDATA.
  - RDATA: capture data_i into reg_rdata_o, go to RWAIT.
  - RWAIT: wait for dir=0, then ack and go to IDLE. Ack is 1 cycle after dir falls (turnaround).
- Abort: dir rising while in CMD or WDATA, or dir=1 with nxt=1 in RTURN, means the PHY RX has priority.
  - data_o=0 and stp_o=0; go to ABORT.
  - ABORT waits for dir=0 plus one turnaround cycle, increments retry, then re-enters CMD with the same latched access.
  - When retry reaches MAX_RETRY: ack with err=1 and go to IDLE.
- Timeout: counter runs while in CMD/WDATA with dir=0 and nxt=0.
  - On reaching TIMEOUT: assert stp for 1 cycle, then ack with err=1.
  - An internal init access that fails is still counted as done. init_done_o still sets after the second write.
- init_done_o: sets the cycle the FUNC_CTRL write acks. It never sets before that ack.
- Bus drive rule: data_o=0 whenever dir=1 or the FSM is in IDLE.
- RX CMD: when dir=1, previous dir=1, nxt=0, and the FSM is not in RTURN/RDATA:
  - rxcmd_o <= data_i and rxcmd_valid_o=1 for that cycle.
  - Cycles with nxt=1 (packet data) are ignored.
- Simultaneous events:
  - External request with the FSM busy: held, not acked.
  - dir rising on the same cycle as nxt in CMD: treated as an abort, not a completion.
  - Read-data cycle is never reported as an RX CMD.

Test Plan:
- Init: release reset, PHY model acks nxt on 2nd TXCMD cycle -> no bus activity for 6000 cycles. TXCMD 8'h8A, data 8'h00, stp; then 8'h84, 8'h48, stp. init_done_o=1 one cycle after second stp; no reg_ack_o pulses.
- Write: reg_we=1, addr 6'h16, wdata 8'h5A -> data_o 8'h96 until nxt, 8'h5A until nxt, stp 1 cycle. reg_ack_o 1 cycle later with err=0.
- Read: addr 6'h00, PHY dir high after nxt, returns 8'h24 -> rdata=8'h24 and ack one cycle after dir falls. No rxcmd_valid_o pulse during the read.
- Abort/retry: PHY raises dir with nxt=1 during TXCMD for 3 attempts, sending RX CMD 8'h01 -> three rxcmd_valid_o pulses with rxcmd_o=8'h01. Access then completes with err=0. With 8 aborts instead: ack with err=1.
- Timeout: PHY never asserts nxt -> after 255 cycles, stp pulse and ack with err=1. The next request proceeds normally.
- Reset mid-read (in RWAIT): rst_i low -> all outputs 0 asynchronously. After release, WAIT_INIT restarts and init_done_o=0 until reconfiguration completes.

Source files
------------

// File: rtl/ulpi_reg_ctrl_if.sv
// Register-client port of the ULPI register controller.
// master: client (req/we/addr/wdata out), slave: controller (ack/err/rdata out).
interface ulpi_reg_ctrl_if;
    logic       req;
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic       ack;
    logic       err;
    logic [7:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, err, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, err, rdata
    );
endinterface

// File: rtl/ulpi_reg_ctrl.sv
// ULPI link-side register controller: PHY init writes, one register port, RX CMD tap.
// Ports: clk_i/rst_i, ULPI data/dir/nxt/stp, reg_bus (slave), init_done_o, rxcmd_o/valid.
module ulpi_reg_ctrl #(
    parameter logic [15:0] INIT_DELAY     = 16'd6000,
    parameter logic [7:0]  OTG_CTRL_INIT  = 8'h00,
    parameter logic [7:0]  FUNC_CTRL_INIT = 8'h48,
    parameter logic [7:0]  TIMEOUT        = 8'd255,
    parameter logic [3:0]  MAX_RETRY      = 4'd8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [7:0]     ulpi_data_i,
    output logic [7:0]     ulpi_data_o,
    input  logic           ulpi_dir_i,
    input  logic           ulpi_nxt_i,
    output logic           ulpi_stp_o,
    ulpi_reg_ctrl_if.slave reg_bus,
    output logic           init_done_o,
    output logic [7:0]     rxcmd_o,
    output logic           rxcmd_valid_o
);
    typedef enum logic [3:0] {
        WAIT_INIT, IDLE, CMD, WDATA, STP,
        RTURN, RDATA, RWAIT, ABORT
    } state_t;

    state_t      state, state_n;
    logic [15:0] dcnt;
    logic [7:0]  tcnt;
    logic [3:0]  retry;
    logic        we_q, is_int, to_err, dir_q;
    logic [5:0]  addr_q;
    logic [7:0]  wdata_q, rd_buf;
    logic [1:0]  init_idx;
    logic        ack_q, err_q;
    logic [7:0]  rdata_q;

    logic int_pend, accept, fin, fin_err;
    logic t_clr, t_inc, r_inc, to_set, cap;

    // init_idx: 0 = OTG write pending, 1 = FUNC write pending, 2 = done
    assign int_pend = (init_idx != 2'd2);

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        fin     = 1'b0;
        fin_err = 1'b0;
        t_clr   = 1'b0;
        t_inc   = 1'b0;
        r_inc   = 1'b0;
        to_set  = 1'b0;
        cap     = 1'b0;
        unique case (state)
            WAIT_INIT: begin
                if (dcnt == INIT_DELAY - 16'd1)
                    state_n = IDLE;
            end
            IDLE: begin
                // two idle dir cycles: no turnaround pending
                if (!ulpi_dir_i && !dir_q &&
                    (int_pend || (reg_bus.req && init_done_o))) begin
                    accept  = 1'b1;
                    state_n = CMD;
                end
            end
            CMD, WDATA: begin
                if (ulpi_dir_i) begin
                    state_n = ABORT;
                end else if (ulpi_nxt_i) begin
                    t_clr = 1'b1;
                    if (state == WDATA)
                        state_n = STP;
                    else
                        state_n = we_q ? WDATA : RTURN;
                end else if (tcnt == TIMEOUT - 8'd1) begin
                    to_set  = 1'b1;
                    state_n = STP;
                end else begin
                    t_inc = 1'b1;
                end
            end
            STP: begin
                fin     = 1'b1;
                fin_err = to_err;
                state_n = IDLE;
            end
            RTURN: begin
                if (ulpi_dir_i && !ulpi_nxt_i)
                    state_n = RDATA;
                else
                    state_n = ABORT;
            end
            RDATA: begin
                cap     = 1'b1;
                state_n = RWAIT;
            end
            RWAIT: begin
                if (!ulpi_dir_i) begin
                    fin     = 1'b1;
                    state_n = IDLE;
                end
            end
            ABORT: begin
                if (!ulpi_dir_i && !dir_q) begin
                    r_inc = 1'b1;
                    if (retry == MAX_RETRY - 4'd1) begin
                        fin     = 1'b1;
                        fin_err = 1'b1;
                        state_n = IDLE;
                    end else begin
                        t_clr   = 1'b1;
                        state_n = CMD;
                    end
                end
            end
            default: state_n = WAIT_INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state         <= WAIT_INIT;
            dcnt          <= '0;
            tcnt          <= '0;
            retry         <= '0;
            we_q          <= 1'b0;
            is_int        <= 1'b0;
            to_err        <= 1'b0;
            dir_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rd_buf        <= '0;
            init_idx      <= '0;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            init_done_o   <= 1'b0;
            rxcmd_o       <= '0;
            rxcmd_valid_o <= 1'b0;
        end else begin
            state         <= state_n;
            dir_q         <= ulpi_dir_i;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            rxcmd_valid_o <= 1'b0;
            if (state == WAIT_INIT)
                dcnt <= dcnt + 16'd1;
            if (accept) begin
                is_int <= int_pend;
                retry  <= '0;
                to_err <= 1'b0;
                if (int_pend) begin
                    we_q    <= 1'b1;
                    addr_q  <= (init_idx == 2'd0) ? 6'h0A : 6'h04;
                    wdata_q <= (init_idx == 2'd0) ? OTG_CTRL_INIT
                                                  : FUNC_CTRL_INIT;
                end else begin
                    we_q    <= reg_bus.we;
                    addr_q  <= reg_bus.addr;
                    wdata_q <= reg_bus.wdata;
                end
            end
            if (accept || t_clr)
                tcnt <= '0;
            else if (t_inc)
                tcnt <= tcnt + 8'd1;
            if (r_inc)
                retry <= retry + 4'd1;
            if (to_set)
                to_err <= 1'b1;
            if (cap)
                rd_buf <= ulpi_data_i;
            if (fin) begin
                // a failed init write still advances the sequence
                if (is_int) begin
                    init_idx <= init_idx + 2'd1;
                    if (init_idx == 2'd1)
                        init_done_o <= 1'b1;
                end else begin
                    ack_q <= 1'b1;
                    err_q <= fin_err;
                    if (!we_q && !fin_err)
                        rdata_q <= rd_buf;
                end
            end
            if (ulpi_dir_i && dir_q && !ulpi_nxt_i &&
                state != RTURN && state != RDATA) begin
                rxcmd_o       <= ulpi_data_i;
                rxcmd_valid_o <= 1'b1;
            end
        end
    end

    always_comb begin
        ulpi_data_o = 8'h00;
        if (!ulpi_dir_i) begin
            unique case (state)
                CMD:     ulpi_data_o = {we_q ? 2'b10 : 2'b11, addr_q};
                WDATA:   ulpi_data_o = wdata_q;
                default: ulpi_data_o = 8'h00;
            endcase
        end
    end

    assign ulpi_stp_o    = (state == STP);
    assign reg_bus.ack   = ack_q;
    assign reg_bus.err   = err_q;
    assign reg_bus.rdata = rdata_q;
endmodule
